// File: rtl/wb_commit.sv
// Writeback/commit stage: retires one instruction per handshake, waits for and
// formats load data, and drives the register-file write port with registered pulses.
module wb_commit #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned TO_W         = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wr_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lsb,
  input  logic [31:0] in_result,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rd_data,
  input  logic        flush,
  output logic [4:0]  rd,
  output logic [31:0] rd_wr_data,
  output logic        rd_wr_en,
  output logic        retired,
  output logic        load_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t              state, state_nx;
  logic [TO_W-1:0]     cnt, cnt_nx, cnt_inc;
  logic [RW-1:0]       lat_rd, lat_rd_nx;
  logic                lat_wr, lat_wr_nx;
  logic [2:0]          lat_f3, lat_f3_nx;
  logic [1:0]          lat_lsb, lat_lsb_nx;
  logic [RW-1:0]       rd_nx;
  logic [XLEN-1:0]     data_nx;
  logic                en_nx, ret_nx, err_nx;
  logic                f3_legal, misaligned;

  // Select byte/half by address offset, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                               input logic [1:0] lsb,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lsb[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'b0, b};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign in_ready   = (state == IDLE);
  assign cnt_inc    = cnt + TO_W'(1);
  assign f3_legal   = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                      (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr_lsb[0]) ||
                      ((in_funct3 == 3'b010) && (in_addr_lsb != 2'b00));

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lat_rd_nx  = lat_rd;
    lat_wr_nx  = lat_wr;
    lat_f3_nx  = lat_f3;
    lat_lsb_nx = lat_lsb;
    rd_nx      = rd;
    data_nx    = rd_wr_data;
    en_nx      = 1'b0;
    ret_nx     = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            rd_nx   = in_rd;
            data_nx = in_result;
            en_nx   = in_wr_rd && (in_rd != '0);
            ret_nx  = 1'b1;
          end else if (!f3_legal || misaligned) begin
            err_nx = 1'b1;
          end else if (dmem_ack) begin
            rd_nx   = in_rd;
            data_nx = fmt_load(in_funct3, in_addr_lsb, dmem_rd_data);
            en_nx   = in_wr_rd && (in_rd != '0);
            ret_nx  = 1'b1;
          end else begin
            lat_rd_nx  = in_rd;
            lat_wr_nx  = in_wr_rd;
            lat_f3_nx  = in_funct3;
            lat_lsb_nx = in_addr_lsb;
            cnt_nx     = '0;
            state_nx   = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        cnt_nx = cnt_inc;
        if (flush) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (dmem_ack) begin
          rd_nx    = lat_rd;
          data_nx  = fmt_load(lat_f3, lat_lsb, dmem_rd_data);
          en_nx    = lat_wr && (lat_rd != '0);
          ret_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt_inc == TO_W'(LOAD_TIMEOUT)) begin
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latched load context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_rd     <= '0;
      lat_wr     <= 1'b0;
      lat_f3     <= '0;
      lat_lsb    <= '0;
      rd         <= '0;
      rd_wr_data <= '0;
      rd_wr_en   <= 1'b0;
      retired    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lat_rd     <= lat_rd_nx;
      lat_wr     <= lat_wr_nx;
      lat_f3     <= lat_f3_nx;
      lat_lsb    <= lat_lsb_nx;
      rd         <= rd_nx;
      rd_wr_data <= data_nx;
      rd_wr_en   <= en_nx;
      retired    <= ret_nx;
      load_err   <= err_nx;
    end
  end

endmodule
